// File: rtl/vector_lsu.sv
// Vector load/store unit: one line command at a time, driving the 512x32 line memory
// and returning load data or store completion on a valid/ready response channel.
module vector_lsu #(
  parameter int ADDR_W = 9,
  parameter int WORD_W = 32,
  parameter int LANES  = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_store,
  input  logic [ADDR_W-1:0]       cmd_addr,
  input  logic [LANES*WORD_W-1:0] cmd_wdata,
  output logic                    resp_valid,
  input  logic                    resp_ready,
  output logic                    resp_store,
  output logic                    resp_err,
  output logic [LANES*WORD_W-1:0] resp_rdata,
  output logic [ADDR_W-1:0]       mem_addr,
  output logic [LANES*WORD_W-1:0] mem_wr_data,
  output logic                    mem_wr_en,
  input  logic [LANES*WORD_W-1:0] mem_rd_data,
  output logic                    busy
);

  localparam int LINE_W = LANES * WORD_W;
  localparam int OFF_W  = $clog2(LANES);

  typedef enum logic [2:0] {
    IDLE,
    LD_ISSUE,
    LD_CAP,
    ST_WR,
    RESP
  } state_t;

  state_t state, state_nxt;

  logic [ADDR_W-1:0] mem_addr_nxt;
  logic [LINE_W-1:0] mem_wr_data_nxt;
  logic              mem_wr_en_nxt;
  logic              resp_valid_nxt;
  logic              resp_store_nxt;
  logic              resp_err_nxt;
  logic [LINE_W-1:0] resp_rdata_nxt;

  // A line must start on a LANES-word boundary so addr+LANES-1 stays in range.
  function automatic logic is_aligned(input logic [ADDR_W-1:0] a);
    return a[OFF_W-1:0] == '0;
  endfunction

  assign cmd_ready = rst_n & (state == IDLE);
  assign busy      = (state != IDLE);

  always_comb begin
    state_nxt       = state;
    mem_addr_nxt    = mem_addr;
    mem_wr_data_nxt = mem_wr_data;
    mem_wr_en_nxt   = 1'b0;
    resp_valid_nxt  = resp_valid;
    resp_store_nxt  = resp_store;
    resp_err_nxt    = resp_err;
    resp_rdata_nxt  = resp_rdata;
    case (state)
      IDLE: begin
        if (cmd_valid) begin
          if (!is_aligned(cmd_addr)) begin
            state_nxt      = RESP;
            resp_valid_nxt = 1'b1;
            resp_err_nxt   = 1'b1;
            resp_store_nxt = cmd_store;
            resp_rdata_nxt = '0;
          end else if (cmd_store) begin
            state_nxt       = ST_WR;
            mem_addr_nxt    = cmd_addr;
            mem_wr_data_nxt = cmd_wdata;
            mem_wr_en_nxt   = 1'b1;
          end else begin
            state_nxt    = LD_ISSUE;
            mem_addr_nxt = cmd_addr;
          end
        end
      end
      // memory registers the addressed line at the end of this cycle
      LD_ISSUE: begin
        state_nxt = LD_CAP;
      end
      LD_CAP: begin
        state_nxt      = RESP;
        resp_valid_nxt = 1'b1;
        resp_rdata_nxt = mem_rd_data;
        resp_err_nxt   = 1'b0;
        resp_store_nxt = 1'b0;
      end
      // the write lands at the closing edge of this cycle
      ST_WR: begin
        state_nxt      = RESP;
        resp_valid_nxt = 1'b1;
        resp_store_nxt = 1'b1;
        resp_err_nxt   = 1'b0;
        resp_rdata_nxt = '0;
      end
      RESP: begin
        if (resp_ready) begin
          state_nxt      = IDLE;
          resp_valid_nxt = 1'b0;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      mem_addr    <= '0;
      mem_wr_data <= '0;
      mem_wr_en   <= 1'b0;
      resp_valid  <= 1'b0;
      resp_store  <= 1'b0;
      resp_err    <= 1'b0;
      resp_rdata  <= '0;
    end else begin
      state       <= state_nxt;
      mem_addr    <= mem_addr_nxt;
      mem_wr_data <= mem_wr_data_nxt;
      mem_wr_en   <= mem_wr_en_nxt;
      resp_valid  <= resp_valid_nxt;
      resp_store  <= resp_store_nxt;
      resp_err    <= resp_err_nxt;
      resp_rdata  <= resp_rdata_nxt;
    end
  end

endmodule

// File: tb/tb_vector_lsu.sv
// Bench for vector_lsu: line memory environment, transaction-level reference model
// with per-cycle comparison, and directed scenarios with literal expectations.
module tb_vector_lsu;

  localparam int LW = 512;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cmd_valid = 1'b0;
  logic          cmd_ready;
  logic          cmd_store = 1'b0;
  logic [8:0]    cmd_addr = '0;
  logic [LW-1:0] cmd_wdata = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b0;
  logic          resp_store;
  logic          resp_err;
  logic [LW-1:0] resp_rdata;
  logic [8:0]    mem_addr;
  logic [LW-1:0] mem_wr_data;
  logic          mem_wr_en;
  logic [LW-1:0] mem_rd_data = '0;
  logic          busy;

  vector_lsu dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_store(cmd_store),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_store(resp_store),
    .resp_err(resp_err), .resp_rdata(resp_rdata),
    .mem_addr(mem_addr), .mem_wr_data(mem_wr_data), .mem_wr_en(mem_wr_en),
    .mem_rd_data(mem_rd_data), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int wr_pulses = 0;

  logic [31:0] tb_mem  [512];
  logic [31:0] ref_mem [512];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [LW-1:0] act, input logic [LW-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tfail(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out", name);
  endtask

  function automatic logic [LW-1:0] mk_line(input logic [31:0] base);
    logic [LW-1:0] l;
    for (int k = 0; k < 16; k++) l[511-32*k -: 32] = base + 32'(k);
    return l;
  endfunction

  function automatic logic [LW-1:0] env_line(input logic [8:0] a);
    logic [LW-1:0] l;
    for (int k = 0; k < 16; k++) l[511-32*k -: 32] = tb_mem[a + 9'(k)];
    return l;
  endfunction

  function automatic logic [LW-1:0] ref_line(input logic [8:0] a);
    logic [LW-1:0] l;
    for (int k = 0; k < 16; k++) l[511-32*k -: 32] = ref_mem[a + 9'(k)];
    return l;
  endfunction

  // Line memory: registered read, write of all 16 words when wr_en is sampled high.
  always @(posedge clk) begin
    mem_rd_data <= env_line(mem_addr);
    if (mem_wr_en == 1'b1) begin
      wr_pulses <= wr_pulses + 1;
      for (int k = 0; k < 16; k++) tb_mem[mem_addr + 9'(k)] = mem_wr_data[511-32*k -: 32];
    end
  end

  // Reference model: one outstanding transaction, response visible once
  // the number of edges since acceptance reaches the command's latency.
  bit            m_init = 1'b0;
  bit            m_pend = 1'b0;
  bit            m_vis = 1'b0;
  logic          m_store = 1'b0;
  logic          m_err = 1'b0;
  int            m_n = 0;
  int            m_lat = 0;
  logic [8:0]    m_addr = '0;
  logic [LW-1:0] m_wdata = '0;
  logic [LW-1:0] m_rdata = '0;

  always @(posedge clk) begin
    if (!rst_n) begin
      m_init = 1'b1;
      m_pend = 1'b0;
      m_vis  = 1'b0;
    end else if (m_pend) begin
      if (m_vis && resp_ready) begin
        m_pend = 1'b0;
        m_vis  = 1'b0;
      end else begin
        m_n++;
        m_vis = (m_n >= m_lat);
      end
    end else if (cmd_valid) begin
      m_pend  = 1'b1;
      m_n     = 1;
      m_store = cmd_store;
      m_addr  = cmd_addr;
      m_wdata = cmd_wdata;
      m_err   = (cmd_addr[3:0] != 4'd0);
      m_lat   = m_err ? 1 : (cmd_store ? 2 : 3);
      m_rdata = '0;
      if (!m_err) begin
        if (cmd_store) begin
          for (int k = 0; k < 16; k++) ref_mem[cmd_addr + 9'(k)] = cmd_wdata[511-32*k -: 32];
        end else begin
          m_rdata = ref_line(cmd_addr);
        end
      end
      m_vis = (m_n >= m_lat);
    end
  end

  always @(negedge clk) begin
    if (m_init) begin
      chk("cmd_ready", LW'(cmd_ready), LW'(rst_n && !m_pend));
      chk("busy", LW'(busy), LW'(m_pend));
      chk("resp_valid", LW'(resp_valid), LW'(m_vis));
      if (m_vis) begin
        chk("resp_store", LW'(resp_store), LW'(m_store));
        chk("resp_err", LW'(resp_err), LW'(m_err));
        chk("resp_rdata", resp_rdata, m_rdata);
      end
      chk("mem_wr_en", LW'(mem_wr_en), LW'(m_pend && m_store && !m_err && m_n == 1));
      if (m_pend && !m_err && !m_vis) begin
        chk("mem_addr", LW'(mem_addr), LW'(m_addr));
        if (m_store) chk("mem_wr_data", mem_wr_data, m_wdata);
      end
    end
  end

  task automatic send_cmd(input logic st, input logic [8:0] a, input logic [LW-1:0] wd,
                          output int acc);
    int g = 0;
    cmd_valid = 1'b1;
    cmd_store = st;
    cmd_addr  = a;
    cmd_wdata = wd;
    while (!cmd_ready && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (!cmd_ready) tfail("cmd_accept");
    @(posedge clk); #1;
    acc = cyc;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_resp(input int acc, output int lat, output logic rs, output logic re,
                           output logic [LW-1:0] rd);
    int g = 0;
    while (!resp_valid && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (!resp_valid) tfail("resp_wait");
    lat = cyc - acc + 1;
    rs  = resp_store;
    re  = resp_err;
    rd  = resp_rdata;
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
  endtask

  initial begin
    int acc, lat, p0, g;
    logic rs, re;
    logic [LW-1:0] rd, line1000, line1f0;

    for (int i = 0; i < 512; i++) begin
      tb_mem[i]  = 32'hA500_0000 | 32'(i);
      ref_mem[i] = 32'hA500_0000 | 32'(i);
    end
    line1000 = mk_line(32'h1000);
    line1f0  = mk_line(32'h1F0);

    // Reset held with a command pending
    rst_n = 1'b0;
    cmd_valid = 1'b1; cmd_store = 1'b1; cmd_addr = 9'h010; cmd_wdata = line1000;
    repeat (3) begin
      @(posedge clk); #1;
      chk("rst_cmd_ready", LW'(cmd_ready), LW'(0));
    end
    chk("rst_mem_addr", LW'(mem_addr), LW'(0));
    chk("rst_mem_wr_data", mem_wr_data, '0);
    chk("rst_mem_wr_en", LW'(mem_wr_en), LW'(0));
    chk("rst_resp_valid", LW'(resp_valid), LW'(0));
    chk("rst_resp_store", LW'(resp_store), LW'(0));
    chk("rst_resp_err", LW'(resp_err), LW'(0));
    chk("rst_resp_rdata", resp_rdata, '0);
    chk("rst_busy", LW'(busy), LW'(0));
    chk("rst_wr_pulses", LW'(wr_pulses), LW'(0));
    cmd_valid = 1'b0;
    rst_n = 1'b1;
    #1;
    chk("release_cmd_ready", LW'(cmd_ready), LW'(1));
    @(posedge clk); #1;

    // Aligned store
    p0 = wr_pulses;
    send_cmd(1'b1, 9'h010, line1000, acc);
    chk("st_wr_en", LW'(mem_wr_en), LW'(1));
    chk("st_mem_addr", LW'(mem_addr), LW'(9'h010));
    wait_resp(acc, lat, rs, re, rd);
    chk("st_latency", LW'(lat), LW'(2));
    chk("st_resp_store", LW'(rs), LW'(1));
    chk("st_resp_err", LW'(re), LW'(0));
    chk("st_resp_rdata", rd, '0);
    chk("st_pulses", LW'(wr_pulses - p0), LW'(1));
    chk("st_mem_first", LW'(tb_mem[9'h010]), LW'(32'h1000));
    chk("st_mem_last", LW'(tb_mem[9'h01F]), LW'(32'h100F));

    // Load of the stored line
    send_cmd(1'b0, 9'h010, '0, acc);
    wait_resp(acc, lat, rs, re, rd);
    chk("ld_latency", LW'(lat), LW'(3));
    chk("ld_resp_store", LW'(rs), LW'(0));
    chk("ld_resp_err", LW'(re), LW'(0));
    chk("ld_word0", LW'(rd[511:480]), LW'(32'h1000));
    chk("ld_word15", LW'(rd[31:0]), LW'(32'h100F));
    chk("ld_line", rd, line1000);

    // Misaligned store is rejected without touching memory
    p0 = wr_pulses;
    send_cmd(1'b1, 9'h013, mk_line(32'hDEAD0000), acc);
    wait_resp(acc, lat, rs, re, rd);
    chk("mis_latency", LW'(lat), LW'(1));
    chk("mis_resp_err", LW'(re), LW'(1));
    chk("mis_resp_store", LW'(rs), LW'(1));
    chk("mis_resp_rdata", rd, '0);
    chk("mis_pulses", LW'(wr_pulses - p0), LW'(0));
    send_cmd(1'b0, 9'h010, '0, acc);
    wait_resp(acc, lat, rs, re, rd);
    chk("mis_followup_line", rd, line1000);

    // Misaligned load and a never-written line
    send_cmd(1'b0, 9'h1FF, '0, acc);
    wait_resp(acc, lat, rs, re, rd);
    chk("misld_latency", LW'(lat), LW'(1));
    chk("misld_err", LW'(re), LW'(1));
    chk("misld_store", LW'(rs), LW'(0));
    send_cmd(1'b0, 9'h100, '0, acc);
    wait_resp(acc, lat, rs, re, rd);
    chk("init_line", rd, mk_line(32'hA500_0100));

    // Backpressure on a load response with a store waiting
    send_cmd(1'b0, 9'h010, '0, acc);
    g = 0;
    while (!resp_valid && g < 50) begin
      @(posedge clk); #1;
      g++;
    end
    if (!resp_valid) tfail("bp_resp_wait");
    chk("bp_latency", LW'(cyc - acc + 1), LW'(3));
    cmd_valid = 1'b1; cmd_store = 1'b1; cmd_addr = 9'h1F0; cmd_wdata = line1f0;
    repeat (5) begin
      @(posedge clk); #1;
      chk("bp_valid", LW'(resp_valid), LW'(1));
      chk("bp_rdata", resp_rdata, line1000);
      chk("bp_store", LW'(resp_store), LW'(0));
      chk("bp_cmd_ready", LW'(cmd_ready), LW'(0));
    end
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    chk("bp_after_hs_ready", LW'(cmd_ready), LW'(1));
    chk("bp_after_hs_valid", LW'(resp_valid), LW'(0));
    @(posedge clk); #1;
    acc = cyc;
    cmd_valid = 1'b0;
    chk("bp_pending_accepted", LW'(busy), LW'(1));
    chk("bp_pending_wr_en", LW'(mem_wr_en), LW'(1));
    chk("bp_pending_addr", LW'(mem_addr), LW'(9'h1F0));
    wait_resp(acc, lat, rs, re, rd);
    chk("top_st_latency", LW'(lat), LW'(2));
    chk("top_st_store", LW'(rs), LW'(1));

    // Top line read back
    send_cmd(1'b0, 9'h1F0, '0, acc);
    wait_resp(acc, lat, rs, re, rd);
    chk("top_ld_word0", LW'(rd[511:480]), LW'(32'h1F0));
    chk("top_ld_word15", LW'(rd[31:0]), LW'(32'h1FF));
    chk("top_ld_line", rd, line1f0);

    // Reset during LD_CAP abandons the load
    send_cmd(1'b0, 9'h1F0, '0, acc);
    @(posedge clk); #1;
    chk("midrst_busy_before", LW'(busy), LW'(1));
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("midrst_valid", LW'(resp_valid), LW'(0));
    chk("midrst_busy", LW'(busy), LW'(0));
    chk("midrst_rdata", resp_rdata, '0);
    rst_n = 1'b1;
    #1;
    chk("midrst_cmd_ready", LW'(cmd_ready), LW'(1));
    repeat (4) begin
      @(posedge clk); #1;
      chk("midrst_no_resp", LW'(resp_valid), LW'(0));
    end

    send_cmd(1'b0, 9'h1F0, '0, acc);
    wait_resp(acc, lat, rs, re, rd);
    chk("post_rst_latency", LW'(lat), LW'(3));
    chk("post_rst_line", rd, line1f0);

    repeat (2) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/vector_lsu.md
Name: vector_lsu

Overview:
- Vector load/store unit sitting directly upstream of the 512x32 line memory.
- Accepts one load or store command at a time over a valid/ready handshake and drives the memory's addr/wr_data/wr_en port.
- Captures the memory's registered 512-bit read line and returns load data or store completion over a valid/ready response channel.
- Rejects misaligned lines so the memory never sees an out-of-range word index.

Parameters:
- ADDR_W, 9, memory word-address width
- WORD_W, 32, memory word width
- LANES, 16, words per vector line; line width = LANES*WORD_W = 512

Ports:
- clk  in  1  clock; all logic on posedge
- rst_n  in  1  synchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  unit can accept a command
- cmd_store  in  1  1 = store, 0 = load
- cmd_addr  in  ADDR_W  word address of the line's first word
- cmd_wdata  in  512  store line; the word at cmd_addr is in bits [511:480]
- resp_valid  out  1  response present
- resp_ready  in  1  consumer accepts response
- resp_store  out  1  response belongs to a store
- resp_err  out  1  command rejected (misaligned)
- resp_rdata  out  512  load line; 0 for stores and errors
- mem_addr  out  ADDR_W  to memory addr
- mem_wr_data  out  512  to memory wr_data
- mem_wr_en  out  1  to memory wr_en
- mem_rd_data  in  512  from memory rd_data (registered, 1-cycle latency)
- busy  out  1  state != IDLE

Behaviour:
- Reset (rst_n low at posedge):
  - state <= IDLE.
  - mem_addr, mem_wr_data, mem_wr_en, resp_valid, resp_store, resp_err and resp_rdata <= 0.
  - cmd_ready is forced 0 while rst_n is low.
  - Reset mid-operation abandons the command with no response. A store write completes only if its write cycle has already passed; there are never partial writes.
- cmd_ready = rst_n & (state == IDLE). Acceptance happens at the edge where cmd_valid & cmd_ready.
- Alignment: a command is legal iff cmd_addr[3:0] == 0, which guarantees addr+15 <= 511. Line layout: word addr+k <-> bits [511-32k -: 32].
- State IDLE, on accept:
  - If misaligned -> RESP, with resp_err=1, resp_store=cmd_store, resp_rdata=0. No memory access occurs and mem_wr_en stays 0.
  - If legal load -> LD_ISSUE; mem_addr <= cmd_addr.
  - If legal store -> ST_WR; mem_addr <= cmd_addr, mem_wr_data <= cmd_wdata, mem_wr_en <= 1.
- LD_ISSUE: mem_wr_en = 0 and mem_addr is stable. The memory registers the line at this edge. -> LD_CAP.
- LD_CAP: resp_rdata <= mem_rd_data, resp_err <= 0, resp_store <= 0. -> RESP.
- ST_WR: mem_wr_en is high for exactly this one cycle, and the memory writes at the closing edge. mem_wr_en <= 0, resp_store <= 1, resp_err <= 0, resp_rdata <= 0. -> RESP.
- RESP:
  - resp_valid = 1. All resp_* outputs are held stable until resp_valid & resp_ready.
  - On handshake: resp_valid <= 0 -> IDLE. The next command can be accepted at the following edge.
- Latency, counted in edges from the accept edge to resp_valid visible:
  - load = 3 edges
  - store = 2 edges
  - error = 1 edge
  - Minimum occupancy per command, including the response handshake: load 4 cycles, store 3 cycles.
- mem_addr holds its last value while IDLE, so the memory keeps re-reading harmlessly. mem_wr_en is 0 in every state except ST_WR.
- Strictly one outstanding command, so there is no load-after-store hazard: a load issued after a store's response reads the stored data.
- A cmd_valid that drops without a handshake has no effect. Command inputs are sampled only at the accept edge.

Test Plan:
- Reset: rst_n=0 for 3 cycles with cmd_valid=1 -> cmd_ready=0, all outputs 0, mem_wr_en never 1. After release, cmd_ready=1 in the next cycle.
- Store 0x010 with words 0x1000..0x100F (word k = 0x1000+k) -> mem_wr_en high exactly 1 cycle with mem_addr=0x010. resp_valid 2 edges after accept, with resp_store=1, resp_err=0, resp_rdata=0.
- Load 0x010 after that store -> resp_valid 3 edges after accept. resp_rdata[511:480]=0x1000 ... [31:0]=0x100F, resp_store=0, resp_err=0.
- Misaligned store 0x013 -> resp_err=1 after 1 edge, mem_wr_en never asserted. A follow-up load of 0x010 still returns the 0x1000..0x100F pattern.
- Backpressure: a load completes while resp_ready=0 for 5 cycles -> resp_valid, resp_rdata and resp_store stay stable, cmd_ready=0, and a pending cmd_valid is not accepted. After the handshake, the pending command is accepted at the next edge.
- Top line and reset mid-load:
  - Store then load 0x1F0 with words 0x1F0..0x1FF -> the exact line returns.
  - A second load of 0x1F0 with rst_n=0 during LD_CAP -> no resp_valid, state IDLE, cmd_ready=1 after release.
